// File: rtl/spram8_pkg.sv
// Shared types and constants for the spram8 arbiter / access sequencer.
package spram8_pkg;

  localparam int ASZ = 17;  // byte address width (128K)
  localparam int DSZ = 8;   // RAM data width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RDW  = 2'd3
  } state_e;

  // Request fields latched at grant time.
  typedef struct packed {
    logic           wr;
    logic           wd;
    logic [ASZ-1:0] a;
    logic [15:0]    vi;
  } req_t;

  // Next byte address; wraps from the top of the RAM back to zero.
  function automatic logic [ASZ-1:0] addr_inc(input logic [ASZ-1:0] a);
    return a + {{(ASZ-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/spram8_rr2.sv
// Combinational 2-way round-robin picker. pri_i names the requester that
// wins a tie; a lone request always wins. pri_o hands priority to the loser.
module spram8_rr2
  import spram8_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       pri_i,
  output logic [1:0] gnt_o,
  output logic       pri_o
);

  // Pick a winner and compute the priority for the next arbitration.
  always_comb begin
    gnt_o = 2'b00;
    pri_o = pri_i;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = pri_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    if (gnt_o[0])      pri_o = 1'b1;
    else if (gnt_o[1]) pri_o = 1'b0;
  end

endmodule

// File: rtl/spram8_arb.sv
// Two-requester arbiter and byte-port sequencer for a 128K x 8 single-port
// RAM. Word transfers are split into two little-endian byte cycles.
// Memory-side outputs are decoded from state, so an async reset drops them
// immediately and aborts any transfer in flight.
module spram8_arb
  import spram8_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req,
  input  logic [1:0]     wr,
  input  logic [1:0]     wd,
  input  logic [ASZ-1:0] a0,
  input  logic [ASZ-1:0] a1,
  input  logic [15:0]    vi0,
  input  logic [15:0]    vi1,
  output logic [1:0]     ack,
  output logic [1:0]     dv,
  output logic [15:0]    vo,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_ai,
  output logic [DSZ-1:0] mem_vi,
  input  logic [DSZ-1:0] mem_vo
);

  state_e         state_q, state_d;
  logic           pri_q, pri_d;
  logic           id_q, id_d;
  req_t           rq_q, rq_d;
  logic [DSZ-1:0] lo_q, lo_d;

  logic [1:0]     gnt;
  logic           pri_nxt;

  spram8_rr2 u_rr (
    .req_i (req),
    .pri_i (pri_q),
    .gnt_o (gnt),
    .pri_o (pri_nxt)
  );

  // State, priority pointer and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
      id_q    <= 1'b0;
      rq_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      id_q    <= id_d;
      rq_q    <= rq_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state and output decode. ack is gated by rst_n so a held request
  // cannot show a grant while the block is in reset.
  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    id_d    = id_q;
    rq_d    = rq_q;
    lo_d    = lo_q;
    ack     = 2'b00;
    dv      = 2'b00;
    vo      = 16'h0000;
    mem_we  = 1'b0;
    mem_ai  = '0;
    mem_vi  = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ack   = rst_n ? gnt : 2'b00;
          pri_d = pri_nxt;
          id_d  = gnt[1];
          if (gnt[1]) begin
            rq_d.wr = wr[1];
            rq_d.wd = wd[1];
            rq_d.a  = a1;
            rq_d.vi = vi1;
          end else begin
            rq_d.wr = wr[0];
            rq_d.wd = wd[0];
            rq_d.a  = a0;
            rq_d.vi = vi0;
          end
          state_d = LO;
        end
      end
      LO: begin
        mem_ai = rq_q.a;
        mem_we = rq_q.wr;
        mem_vi = rq_q.vi[7:0];
        if (rq_q.wd)      state_d = HI;
        else if (rq_q.wr) state_d = IDLE;
        else              state_d = RDW;
      end
      HI: begin
        mem_ai = addr_inc(rq_q.a);
        mem_we = rq_q.wr;
        mem_vi = rq_q.vi[15:8];
        // RAM is returning the low byte addressed in LO.
        if (!rq_q.wr) lo_d = mem_vo;
        state_d = rq_q.wr ? IDLE : RDW;
      end
      RDW: begin
        dv      = id_q ? 2'b10 : 2'b01;
        vo      = rq_q.wd ? {mem_vo, lo_q} : {8'h00, mem_vo};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spram8_arb.sv
// Bench for spram8_arb with a behavioural byte RAM and a byte-array
// reference of expected memory contents.
module tb_spram8_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, wr, wd, ack, dv;
  logic [16:0] a0, a1, mem_ai;
  logic [15:0] vi0, vi1, vo;
  logic        mem_we;
  logic [7:0]  mem_vi, mem_vo;

  logic [7:0]  ram     [0:131071];
  logic [7:0]  ref_mem [0:131071];

  int total = 0;
  int bad   = 0;

  spram8_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .wd(wd),
    .a0(a0), .a1(a1), .vi0(vi0), .vi1(vi1), .ack(ack), .dv(dv), .vo(vo),
    .mem_we(mem_we), .mem_ai(mem_ai), .mem_vi(mem_vi), .mem_vo(mem_vo)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, read data one cycle after address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_ai] <= mem_vi;
    mem_vo <= ram[mem_ai];
  end

  function automatic logic [16:0] inc17(input logic [16:0] x);
    return x + 17'd1;
  endfunction

  function automatic logic [1:0] oh(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int id, input bit w, input bit d,
                            input logic [16:0] addr, input logic [15:0] v);
    if (id == 1) begin
      wr[1] = w; wd[1] = d; a1 = addr; vi1 = v;
    end else begin
      wr[0] = w; wd[0] = d; a0 = addr; vi0 = v;
    end
  endtask

  // Full transfer, entered and left at a negedge with the DUT in IDLE.
  // Cycle c counts from the ack cycle; every cycle's bus activity is checked.
  task automatic xfer(input int id, input bit w, input bit d,
                      input logic [16:0] addr, input logic [15:0] v);
    logic [15:0] expv;
    int dvc, endc;
    bit exp_we;
    expv = 16'h0;
    set_fields(id, w, d, addr, v);
    req[id] = 1'b1;
    #1 chk("ack", 32'(ack), 32'(oh(id)));
    if (!w) expv = d ? {ref_mem[inc17(addr)], ref_mem[addr]} : {8'h00, ref_mem[addr]};
    else begin
      ref_mem[addr] = v[7:0];
      if (d) ref_mem[inc17(addr)] = v[15:8];
    end
    dvc  = w ? 0 : (d ? 3 : 2);
    endc = w ? (d ? 3 : 2) : (d ? 4 : 3);
    @(posedge clk);
    #1 req[id] = 1'b0;
    // Requester fields change after ack; only the latched copy may be used.
    set_fields(id, 1'($urandom), 1'($urandom), 17'($urandom), 16'($urandom));
    for (int c = 1; c <= endc; c++) begin
      @(negedge clk);
      exp_we = w && (c == 1 || (d && c == 2));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (c == 1) chk("mem_ai_lo", 32'(mem_ai), 32'(addr));
      if (c == 2 && d) chk("mem_ai_hi", 32'(mem_ai), 32'(inc17(addr)));
      if (exp_we) chk("mem_vi", 32'(mem_vi), 32'(c == 1 ? v[7:0] : v[15:8]));
      chk("dv", 32'(dv), 32'(c == dvc ? oh(id) : 2'b00));
      if (c == dvc) chk("vo", 32'(vo), 32'(expv));
    end
    if (w) begin
      chk("ram_lo", 32'(ram[addr]), 32'(ref_mem[addr]));
      if (d) chk("ram_hi", 32'(ram[inc17(addr)]), 32'(ref_mem[inc17(addr)]));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'h0);
    chk({tag, "_dv"}, 32'(dv), 32'h0);
    chk({tag, "_vo"}, 32'(vo), 32'h0);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_ai"}, 32'(mem_ai), 32'h0);
    chk({tag, "_vi"}, 32'(mem_vi), 32'h0);
  endtask

  initial begin
    logic [16:0] addr;
    int r;

    rst_n = 1'b0; req = 2'b00; wr = 2'b00; wd = 2'b00;
    a0 = '0; a1 = '0; vi0 = '0; vi1 = '0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte write then byte read by requester 0.
    xfer(0, 1'b1, 1'b0, 17'h00010, 16'h00A5);
    xfer(0, 1'b0, 1'b0, 17'h00010, 16'h0000);

    // Word write/read by requester 1 across the top-of-RAM wrap.
    xfer(1, 1'b1, 1'b1, 17'h1FFFF, 16'hBEEF);
    chk("wrap_lo", 32'(ram[17'h1FFFF]), 32'hEF);
    chk("wrap_hi", 32'(ram[17'h00000]), 32'hBE);
    xfer(1, 1'b0, 1'b1, 17'h1FFFF, 16'h0000);

    // Prefill the random-test window 0x1FFF8..0x00008.
    for (int i = 0; i < 17; i++) begin
      addr = 17'h1FFF8 + 17'(i);
      xfer(int'($urandom_range(1)), 1'b1, 1'b0, addr, 16'($urandom));
    end

    // Address walk: write, then read back every location.
    for (int i = 0; i < 17; i++)
      xfer(int'($urandom_range(1)), 1'b1, 1'b0, (17'd1 << i) | 17'(i & 3), 16'(i));
    for (int i = 0; i < 17; i++)
      xfer(int'($urandom_range(1)), 1'b0, 1'b0, (17'd1 << i) | 17'(i & 3), 16'h0);

    // Reset during HI of a word write leaves only the low byte written.
    xfer(0, 1'b1, 1'b0, 17'h00100, 16'h0011);
    xfer(0, 1'b1, 1'b0, 17'h00101, 16'h0022);
    set_fields(0, 1'b1, 1'b1, 17'h00100, 16'h1234);
    req[0] = 1'b1;
    #1 chk("rw_ack", 32'(ack), 32'h1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    chk("rw_lo_we", 32'(mem_we), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rw_rst_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[17'h00100] = 8'h34;
    chk("rw_ram_lo", 32'(ram[17'h00100]), 32'h34);
    chk("rw_ram_hi", 32'(ram[17'h00101]), 32'h22);

    // Reset during HI of a word read: outputs drop at once, no dv follows.
    @(negedge clk);
    set_fields(1, 1'b0, 1'b1, 17'h1FFFE, 16'h0);
    req[1] = 1'b1;
    #1 chk("rr_ack", 32'(ack), 32'h2);
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    set_fields(0, 1'b0, 1'b0, 17'h00010, 16'h0);
    set_fields(1, 1'b0, 1'b0, 17'h1FFFF, 16'h0);
    req = 2'b11;
    #1 chk_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_dv", 32'(dv), 32'h0);
    rst_n = 1'b1;

    // Contention after reset: grants alternate 0,1,0,1,... starting with 0.
    for (int g = 0; g < 6; g++) begin
      #1 chk("rr_grant", 32'(ack), 32'(oh(g % 2)));
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        chk("rr_we", 32'(mem_we), 32'h0);
        chk("rr_dv", 32'(dv), 32'(c == 2 ? oh(g % 2) : 2'b00));
        if (c == 2)
          chk("rr_vo", 32'(vo),
              32'({8'h00, ref_mem[(g % 2 == 1) ? 17'h1FFFF : 17'h00010]}));
      end
    end
    req = 2'b00;
    @(negedge clk);

    // Random transfers confined to the prefilled window around the wrap.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(15));
      addr = (r < 8) ? 17'h1FFF8 + 17'(r) : 17'(r - 8);
      xfer(int'($urandom_range(1)), 1'($urandom), 1'($urandom), addr, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
